// File: rtl/manchester_rx_decoder_if.sv
// Signal bundle between a Manchester line receiver and its consumer.
// The slave modport is the decoder side; master is the driver/consumer side.
interface manchester_rx_decoder_if #(
  parameter int DATA_BITS = 8
);
  logic                 ena;
  logic                 mode;
  logic                 line_in;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 code_err;
  logic                 parity_err;
  logic                 busy;

  modport master (
    output ena, mode, line_in,
    input  data_out, data_valid, code_err, parity_err, busy
  );

  modport slave (
    input  ena, mode, line_in,
    output data_out, data_valid, code_err, parity_err, busy
  );
endinterface

// File: rtl/manchester_rx_decoder.sv
// Oversampling Manchester receiver: sync bit + DATA_BITS data bits, MSB first.
// Define MANCHESTER_RX_PARITY_EN to expect a trailing even-parity bit per frame.
module manchester_rx_decoder #(
  parameter int HALF_BIT  = 4,
  parameter int DATA_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  manchester_rx_decoder_if.slave  bus
);
  localparam int CW = $clog2(HALF_BIT);
  localparam int IW = $clog2(2 * HALF_BIT);
`ifdef MANCHESTER_RX_PARITY_EN
  localparam int FRAME_BITS = DATA_BITS + 1;
`else
  localparam int FRAME_BITS = DATA_BITS;
`endif
  localparam int BW = $clog2(FRAME_BITS + 1);

  localparam logic [CW-1:0] SAMPLE_AT = CW'(HALF_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF_BIT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(2 * HALF_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SYNC, DATA} state_t;

  logic                 sync1_q, sync2_q, prev_q;
  state_t               state_q;
  logic                 mode_q;
  logic [CW-1:0]        cnt_q;
  logic                 phase_q;
  logic                 h1_taken_q;
  logic                 h1_q;
  logic [IW-1:0]        idle_cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_out_q;
  logic                 data_valid_q, code_err_q, parity_err_q, busy_q;

  logic line_s, idle_lvl, line_edge, h1_pt, h2_pt, dec_bad, dec_bit, last_bit;

  assign line_s    = sync2_q;
  assign idle_lvl  = ~bus.mode;
  assign line_edge = line_s ^ prev_q;
  assign h1_pt     = (phase_q == 1'b0) && (cnt_q == SAMPLE_AT);
  assign h2_pt     = (phase_q == 1'b1) && (cnt_q == SAMPLE_AT);
  assign dec_bad   = (h1_q == line_s);
  assign dec_bit   = mode_q ? h1_q : line_s;
  assign last_bit  = (bit_idx_q == BIT_LAST);

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.line_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame FSM with half-bit timing, mid-bit resync and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_IDLE;
      mode_q       <= 1'b0;
      cnt_q        <= '0;
      phase_q      <= 1'b0;
      h1_taken_q   <= 1'b0;
      h1_q         <= 1'b0;
      idle_cnt_q   <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      code_err_q   <= 1'b0;
      parity_err_q <= 1'b0;
      if (!bus.ena) begin
        state_q    <= WAIT_IDLE;
        idle_cnt_q <= '0;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          WAIT_IDLE: begin
            if (line_s == idle_lvl) begin
              if (idle_cnt_q == IDLE_LAST) begin
                state_q    <= IDLE;
                idle_cnt_q <= '0;
              end else begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
              end
            end else begin
              idle_cnt_q <= '0;
            end
          end
          IDLE: begin
            if (line_s != idle_lvl) begin
              state_q    <= SYNC;
              busy_q     <= 1'b1;
              mode_q     <= bus.mode;
              cnt_q      <= '0;
              phase_q    <= 1'b0;
              h1_taken_q <= 1'b0;
              bit_idx_q  <= '0;
            end
          end
          SYNC, DATA: begin
            // A mid-bit edge after the first sample realigns the second half.
            if (!phase_q && h1_taken_q && line_edge) begin
              phase_q <= 1'b1;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              phase_q    <= ~phase_q;
              cnt_q      <= '0;
              h1_taken_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
            if (h1_pt) begin
              h1_q       <= line_s;
              h1_taken_q <= 1'b1;
            end
            if (h2_pt) begin
              if (dec_bad || (state_q == SYNC && !dec_bit)) begin
                code_err_q <= 1'b1;
                state_q    <= WAIT_IDLE;
                idle_cnt_q <= '0;
                busy_q     <= 1'b0;
              end else if (state_q == SYNC) begin
                state_q <= DATA;
              end else begin
                bit_idx_q <= bit_idx_q + BW'(1);
                shift_q   <= {shift_q[DATA_BITS-2:0], dec_bit};
                if (last_bit) begin
                  state_q    <= WAIT_IDLE;
                  idle_cnt_q <= '0;
                  busy_q     <= 1'b0;
`ifdef MANCHESTER_RX_PARITY_EN
                  if (^{shift_q, dec_bit}) begin
                    parity_err_q <= 1'b1;
                  end else begin
                    data_out_q   <= shift_q;
                    data_valid_q <= 1'b1;
                  end
`else
                  data_out_q   <= {shift_q[DATA_BITS-2:0], dec_bit};
                  data_valid_q <= 1'b1;
`endif
                end
              end
            end
          end
          default: begin
            state_q <= WAIT_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.code_err   = code_err_q;
  assign bus.parity_err = parity_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_manchester_rx_decoder.sv
// Directed bench for manchester_rx_decoder: frames are built as half-bit level
// lists, expected bytes go to a queue and are popped on every data_valid strobe.
module tb_manchester_rx_decoder;
  localparam int HB = 4;
  localparam int DB = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  manchester_rx_decoder_if #(.DATA_BITS(DB)) bus ();
  manchester_rx_decoder #(.HALF_BIT(HB), .DATA_BITS(DB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int n_valid = 0;
  int n_cerr = 0;
  int n_perr = 0;
  int n_extra = 0;
  int n_both = 0;
  logic [DB-1:0] exp_q[$];
  logic halves[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.data_valid) begin
      n_valid++;
      if (exp_q.size() == 0) n_extra++;
      else check("data_out", {24'b0, bus.data_out}, {24'b0, exp_q.pop_front()});
    end
    if (bus.code_err) n_cerr++;
    if (bus.parity_err) n_perr++;
    if (bus.data_valid && bus.code_err) n_both++;
  end

  task automatic build(input logic [DB-1:0] d, input int bad, input bit par_en, input logic par);
    logic b, f;
    halves.delete();
    for (int i = 0; i <= DB + (par_en ? 1 : 0); i++) begin
      if (i == 0) b = 1'b1;
      else if (i <= DB) b = d[DB-i];
      else b = par;
      f = ~b ^ bus.mode;
      halves.push_back(f);
      halves.push_back((i == bad) ? f : ~f);
    end
  endtask

  task automatic send(input int from, input int upto, input int w1, input int w2);
    for (int i = from; i < upto && i < halves.size(); i++) begin
      bus.line_in = halves[i];
      repeat ((i % 2 == 0) ? w1 : w2) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    bus.line_in = ~bus.mode;
    repeat (n) @(negedge clk);
  endtask

  task automatic set_mode(input logic m);
    bus.ena = 1'b0;
    bus.mode = m;
    bus.line_in = ~m;
    repeat (4) @(negedge clk);
    bus.ena = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_valid(input string tag, input int target, input int budget);
    int k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(tag, n_valid, target);
  endtask

  initial begin
    bus.ena = 1'b0;
    bus.mode = 1'b0;
    bus.line_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'b0, bus.data_out}, 32'h0);
    check("rst_valid", bus.data_valid, 32'h0);
    check("rst_code_err", bus.code_err, 32'h0);
    check("rst_parity_err", bus.parity_err, 32'h0);
    check("rst_busy", bus.busy, 32'h0);
    rst_n = 1'b1;
    bus.ena = 1'b1;
    idle(12);

    // Ideal frame, mode 0
    exp_q.push_back(8'hA5);
    build(8'hA5, -1, 1'b0, 1'b0);
    send(0, 10, HB, HB);
    check("busy_mid_frame", bus.busy, 32'h1);
    send(10, 18, HB, HB);
    bus.line_in = 1'b1;
    expect_valid("a5_latency", 1, 3);
    idle(12);
    check("a5_single_pulse", n_valid, 32'd1);
    check("a5_no_code_err", n_cerr, 32'd0);

    // Mode 1, back-to-back frames with an 8-cycle idle gap
    set_mode(1'b1);
    exp_q.push_back(8'h3C);
    build(8'h3C, -1, 1'b0, 1'b0);
    send(0, 18, HB, HB);
    idle(2 * HB);
    check("3c_valid", n_valid, 32'd2);
    exp_q.push_back(8'hFF);
    build(8'hFF, -1, 1'b0, 1'b0);
    send(0, 18, HB, HB);
    expect_valid("ff_valid", 3, 6);
    idle(12);

    // Coding violation in data bit 3, then a clean frame
    set_mode(1'b0);
    build(8'h5A, 4, 1'b0, 1'b0);
    send(0, 10, HB, HB);
    idle(20);
    check("viol_code_err", n_cerr, 32'd1);
    check("viol_no_valid", n_valid, 32'd3);
    check("viol_data_held", {24'b0, bus.data_out}, 32'hFF);
    exp_q.push_back(8'h81);
    build(8'h81, -1, 1'b0, 1'b0);
    send(0, 18, HB, HB);
    expect_valid("81_valid", 4, 6);
    idle(12);

    // Jitter: half-bits of 5 and 3 cycles
    exp_q.push_back(8'hC3);
    build(8'hC3, -1, 1'b0, 1'b0);
    send(0, 18, 5, 3);
    expect_valid("c3_valid", 5, 6);
    idle(12);
    check("c3_no_code_err", n_cerr, 32'd1);

    // Reset during data bit 4
    build(8'h77, -1, 1'b0, 1'b0);
    send(0, 11, HB, HB);
    rst_n = 1'b0;
    bus.line_in = 1'b1;
    @(negedge clk);
    check("mid_rst_data_out", {24'b0, bus.data_out}, 32'h0);
    check("mid_rst_busy", bus.busy, 32'h0);
    rst_n = 1'b1;
    idle(12);

    // Enable dropped during data bit 2
    build(8'h77, -1, 1'b0, 1'b0);
    send(0, 7, HB, HB);
    check("ena_busy_before", bus.busy, 32'h1);
    bus.ena = 1'b0;
    idle(4);
    check("ena_busy_after", bus.busy, 32'h0);
    bus.ena = 1'b1;
    idle(2 * HB + 2);
    check("abort_no_valid", n_valid, 32'd5);
    check("abort_no_code_err", n_cerr, 32'd1);
    check("abort_data_out", {24'b0, bus.data_out}, 32'h0);
    exp_q.push_back(8'h12);
    build(8'h12, -1, 1'b0, 1'b0);
    send(0, 18, HB, HB);
    expect_valid("12_valid", 6, 6);
    idle(12);

`ifdef MANCHESTER_RX_PARITY_EN
    exp_q.push_back(8'h0F);
    build(8'h0F, -1, 1'b1, 1'b0);
    send(0, 20, HB, HB);
    expect_valid("par_ok_valid", 7, 6);
    idle(12);
    build(8'h0F, -1, 1'b1, 1'b1);
    send(0, 20, HB, HB);
    idle(12);
    check("par_bad_err", n_perr, 32'd1);
    check("par_bad_no_valid", n_valid, 32'd7);
`else
    check("parity_err_quiet", n_perr, 32'd0);
`endif

    check("queue_drained", exp_q.size(), 32'd0);
    check("no_extra_valid", n_extra, 32'd0);
    check("valid_err_exclusive", n_both, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
